// File: rtl/acam_readout_pkg.sv
// Shared types and constants for the ACAM TDC-GPX FIFO1 readout path.
// Also holds the I-mode word field layout used by downstream timestamp processing.
package acam_readout_pkg;

   localparam int unsigned c_ACAM_DATA_W = 28;
   localparam int unsigned c_ACAM_ADR_W  = 4;
   localparam int unsigned c_CYC_CNT_W   = 4;
   localparam int unsigned c_STAT_W      = 32;

   localparam logic [c_ACAM_ADR_W-1:0] c_ACAM_FIFO1_ADDR = 4'h8;

   // I-mode raw word layout
   localparam int unsigned c_IMODE_CHAN_MSB  = 27;
   localparam int unsigned c_IMODE_CHAN_LSB  = 26;
   localparam int unsigned c_IMODE_START_MSB = 25;
   localparam int unsigned c_IMODE_START_LSB = 18;
   localparam int unsigned c_IMODE_SLOPE_BIT = 17;
   localparam int unsigned c_IMODE_HIT_MSB   = 16;
   localparam int unsigned c_IMODE_HIT_LSB   = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      RECOVER = 2'd2
   } readout_state_t;

   typedef struct packed {
      logic [1:0]  channel;
      logic [7:0]  start_num;
      logic        slope;
      logic [16:0] hit;
   } imode_word_t;

   function automatic imode_word_t imode_decode(input logic [c_ACAM_DATA_W-1:0] raw);
      imode_word_t w;
      w.channel   = raw[c_IMODE_CHAN_MSB:c_IMODE_CHAN_LSB];
      w.start_num = raw[c_IMODE_START_MSB:c_IMODE_START_LSB];
      w.slope     = raw[c_IMODE_SLOPE_BIT];
      w.hit       = raw[c_IMODE_HIT_MSB:c_IMODE_HIT_LSB];
      return w;
   endfunction

endpackage

// File: rtl/acam_fifo_readout_if.sv
// Single-entry valid/ready stream carrying raw ACAM words to the timestamp stage.
interface acam_fifo_readout_if;
   import acam_readout_pkg::*;

   logic [c_ACAM_DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/acam_ef_sync.sv
// Two-flop synchronizer for the asynchronous ACAM empty flag; resets to "empty".
module acam_ef_sync #(
   parameter logic g_rst_val = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= g_rst_val;
         sync_q <= g_rst_val;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/acam_fifo_readout.sv
// Reads ACAM TDC-GPX FIFO1 words whenever EF1 deasserts and hands them downstream.
// Optional statistics counters are built when ACAM_READOUT_STATS_EN is defined.
module acam_fifo_readout
   import acam_readout_pkg::*;
#(
   parameter int unsigned               g_rd_low_cycles      = 2,
   parameter int unsigned               g_rd_recovery_cycles = 4,
   parameter logic [c_ACAM_ADR_W-1:0]   g_fifo_addr          = c_ACAM_FIFO1_ADDR
) (
   input  logic                       clk_sys_i,
   input  logic                       rst_n_i,
   input  logic                       enable_i,
   input  logic                       tdc_ef1_i,
   input  logic [c_ACAM_DATA_W-1:0]   tdc_data_i,
   output logic                       tdc_rd_n_o,
   output logic                       tdc_cs_n_o,
   output logic                       tdc_oe_n_o,
   output logic [c_ACAM_ADR_W-1:0]    tdc_adr_o,
   acam_fifo_readout_if.master        out_if,
   output logic                       busy_o,
   output logic [c_STAT_W-1:0]        words_read_o,
   output logic [c_STAT_W-1:0]        stall_cnt_o
);

   localparam logic [c_CYC_CNT_W-1:0] c_LOW_LOAD = c_CYC_CNT_W'(g_rd_low_cycles - 1);
   localparam logic [c_CYC_CNT_W-1:0] c_REC_LOAD = c_CYC_CNT_W'(g_rd_recovery_cycles - 1);

   readout_state_t           state;
   logic [c_CYC_CNT_W-1:0]   cyc_cnt;
   logic                     ef1_s;
   logic                     rd_n_q;
   logic                     cs_n_q;
   logic                     oe_n_q;
   logic [c_ACAM_ADR_W-1:0]  adr_q;
   logic                     busy_q;
   logic [c_ACAM_DATA_W-1:0] out_data_q;
   logic                     out_valid_q;

   acam_ef_sync #(
      .g_rst_val (1'b1)
   ) u_ef_sync (
      .clk_i   (clk_sys_i),
      .rst_n_i (rst_n_i),
      .d_i     (tdc_ef1_i),
      .q_o     (ef1_s)
   );

   // Read sequencer: strobes low for the read window, then a recovery gap
   // long enough for EF1 to reflect the pop before it is looked at again.
   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         cyc_cnt     <= '0;
         rd_n_q      <= 1'b1;
         cs_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         adr_q       <= g_fifo_addr;
         busy_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         adr_q <= g_fifo_addr;

         if (out_valid_q && out_if.out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               // holding a word blocks the next read, so nothing is overwritten
               if (enable_i && !ef1_s && !out_valid_q) begin
                  state   <= READ;
                  cyc_cnt <= c_LOW_LOAD;
                  rd_n_q  <= 1'b0;
                  cs_n_q  <= 1'b0;
                  oe_n_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end

            READ: begin
               if (cyc_cnt == '0) begin
                  out_data_q  <= tdc_data_i;
                  out_valid_q <= 1'b1;
                  rd_n_q      <= 1'b1;
                  cs_n_q      <= 1'b1;
                  oe_n_q      <= 1'b1;
                  cyc_cnt     <= c_REC_LOAD;
                  state       <= RECOVER;
               end else begin
                  cyc_cnt <= cyc_cnt - c_CYC_CNT_W'(1);
               end
            end

            RECOVER: begin
               if (cyc_cnt == '0) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  cyc_cnt <= cyc_cnt - c_CYC_CNT_W'(1);
               end
            end

            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign tdc_rd_n_o       = rd_n_q;
   assign tdc_cs_n_o       = cs_n_q;
   assign tdc_oe_n_o       = oe_n_q;
   assign tdc_adr_o        = adr_q;
   assign busy_o           = busy_q;
   assign out_if.out_data  = out_data_q;
   assign out_if.out_valid = out_valid_q;

`ifdef ACAM_READOUT_STATS_EN
   logic [c_STAT_W-1:0] words_cnt;
   logic [c_STAT_W-1:0] stall_cnt;
   logic                capture_c;
   logic                stall_c;

   assign capture_c = (state == READ) && (cyc_cnt == '0);
   assign stall_c   = (state == IDLE) && enable_i && !ef1_s && out_valid_q;

   // Capture and backpressure statistics; both wrap naturally at 32 bits.
   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         words_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (capture_c) begin
            words_cnt <= words_cnt + c_STAT_W'(1);
         end
         if (stall_c) begin
            stall_cnt <= stall_cnt + c_STAT_W'(1);
         end
      end
   end

   assign words_read_o = words_cnt;
   assign stall_cnt_o  = stall_cnt;
`else
   assign words_read_o = '0;
   assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_acam_fifo_readout.sv
// Bench for acam_fifo_readout: ACAM FIFO model, scoreboard and cycle-level protocol checker.
module tb_acam_fifo_readout;
   import acam_readout_pkg::*;

   localparam int unsigned LOW = 2;
   localparam int unsigned REC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        tdc_ef1 = 1'b1;
   logic [27:0] tdc_data = '0;
   logic        tdc_rd_n_o, tdc_cs_n_o, tdc_oe_n_o, busy_o;
   logic [3:0]  tdc_adr_o;
   logic [31:0] words_read_o, stall_cnt_o;

   acam_fifo_readout_if out_if ();

   acam_fifo_readout #(
      .g_rd_low_cycles      (LOW),
      .g_rd_recovery_cycles (REC),
      .g_fifo_addr          (4'h8)
   ) dut (
      .clk_sys_i    (clk),
      .rst_n_i      (rst_n),
      .enable_i     (enable),
      .tdc_ef1_i    (tdc_ef1),
      .tdc_data_i   (tdc_data),
      .tdc_rd_n_o   (tdc_rd_n_o),
      .tdc_cs_n_o   (tdc_cs_n_o),
      .tdc_oe_n_o   (tdc_oe_n_o),
      .tdc_adr_o    (tdc_adr_o),
      .out_if       (out_if),
      .busy_o       (busy_o),
      .words_read_o (words_read_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   always #4 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ACAM FIFO1 model: word popped as rd_n falls, EF1 updated 10 ns later.
   logic [27:0] acam_q[$];
   logic [27:0] exp_q[$];
   bit          model_on = 1'b0;

   always @(negedge tdc_rd_n_o) begin
      if (model_on) begin
         if (acam_q.size() == 0) begin
            chk("acam_underflow_read", 32'd1, 32'd0);
         end else begin
            tdc_data = acam_q.pop_front();
         end
         #10 tdc_ef1 = (acam_q.size() == 0);
      end
   end

   task automatic load(input logic [27:0] w);
      acam_q.push_back(w);
      exp_q.push_back(w);
      tdc_ef1 = 1'b0;
   endtask

   // Reset as seen by the DUT (sampled on the edge) plus expected synchronised EF1.
   logic rst_q = 1'b0;
   logic ef_m1 = 1'b1, ef_m2 = 1'b1;
   int   cyc = 0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
      if (!rst_n) begin
         ef_m1 <= 1'b1;
         ef_m2 <= 1'b1;
      end else begin
         ef_m1 <= tdc_ef1;
         ef_m2 <= ef_m1;
      end
   end

   // Protocol checker and scoreboard, sampled mid-cycle.
   logic        prev_rd = 1'b1, prev_valid = 1'b0, prev_acc = 1'b0;
   logic [27:0] prev_data = '0, last_word = '0;
   int          low_run = 0, high_run = 0, since_fall = 100;
   bit          had_read = 1'b0;
   int          n_reads = 0, n_deliv = 0;
   logic [31:0] m_words = '0, m_stall = '0;

   always @(negedge clk) begin
      logic exp_busy;
      logic acc;
      if (!rst_q) begin
         chk("rst_rd_n", 32'(tdc_rd_n_o), 32'd1);
         chk("rst_cs_n", 32'(tdc_cs_n_o), 32'd1);
         chk("rst_oe_n", 32'(tdc_oe_n_o), 32'd1);
         chk("rst_valid", 32'(out_if.out_valid), 32'd0);
         chk("rst_data", 32'(out_if.out_data), 32'd0);
         chk("rst_busy", 32'(busy_o), 32'd0);
         chk("rst_adr", 32'(tdc_adr_o), 32'h8);
         chk("rst_words", words_read_o, 32'd0);
         chk("rst_stall", stall_cnt_o, 32'd0);
         prev_rd = 1'b1; prev_valid = 1'b0; prev_acc = 1'b0;
         low_run = 0; high_run = 0; since_fall = 100; had_read = 1'b0;
         m_words = '0; m_stall = '0;
      end else begin
         chk("adr_const", 32'(tdc_adr_o), 32'h8);
         chk("cs_n_with_rd_n", 32'(tdc_cs_n_o), 32'(tdc_rd_n_o));
         chk("oe_n_with_rd_n", 32'(tdc_oe_n_o), 32'(tdc_rd_n_o));

         if (!tdc_rd_n_o && prev_rd) begin
            chk("read_while_holding", 32'(out_if.out_valid), 32'd0);
            if (had_read) chk("recovery_gap", 32'(high_run >= int'(REC)), 32'd1);
            n_reads++; had_read = 1'b1; since_fall = 0; low_run = 1;
         end else begin
            if (since_fall < 100) since_fall++;
            if (!tdc_rd_n_o) low_run++;
         end
         if (tdc_rd_n_o && !prev_rd) begin
            chk("rd_low_len", 32'(low_run), 32'(LOW));
            high_run = 1;
         end else if (tdc_rd_n_o) begin
            high_run++;
         end

         exp_busy = had_read && (since_fall < int'(LOW + REC));
         chk("busy", 32'(busy_o), 32'(exp_busy));

         if (out_if.out_valid && !prev_valid) begin
            chk("valid_on_rd_rise", 32'(tdc_rd_n_o && !prev_rd), 32'd1);
            m_words = m_words + 32'd1;
         end
         if (prev_valid && !prev_acc) begin
            chk("valid_held", 32'(out_if.out_valid), 32'd1);
            chk("data_held", 32'(out_if.out_data), 32'(prev_data));
         end
         if (prev_acc) chk("valid_cleared", 32'(out_if.out_valid), 32'd0);

         acc = out_if.out_valid && out_if.out_ready;
         if (acc) begin
            if (exp_q.size() == 0) chk("unexpected_word", 32'(out_if.out_data), 32'hDEAD);
            else chk("word_data", 32'(out_if.out_data), 32'(exp_q.pop_front()));
            last_word = out_if.out_data;
            n_deliv++;
         end

`ifdef ACAM_READOUT_STATS_EN
         chk("words_read", words_read_o, m_words);
         chk("stall_cnt", stall_cnt_o, m_stall);
         if (!exp_busy && enable && !ef_m2 && out_if.out_valid) m_stall = m_stall + 32'd1;
`else
         chk("words_read_off", words_read_o, 32'd0);
         chk("stall_cnt_off", stall_cnt_o, 32'd0);
`endif
         prev_rd = tdc_rd_n_o; prev_valid = out_if.out_valid;
         prev_acc = acc; prev_data = out_if.out_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rd_low(input int max, output int waited);
      waited = 0;
      while (tdc_rd_n_o !== 1'b0 && waited < max) begin
         step();
         waited++;
      end
      if (tdc_rd_n_o !== 1'b0) chk("timeout_rd_low", 32'(tdc_rd_n_o), 32'd0);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((acam_q.size() != 0 || exp_q.size() != 0 || busy_o || out_if.out_valid) && n < max) begin
         step();
         n++;
      end
      chk("timeout_drain", 32'(exp_q.size() + acam_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, r0, d0;
      logic [31:0] s0;
      out_if.out_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b1; model_on = 1'b1; enable = 1'b1; out_if.out_ready = 1'b1;
      step();

      // single hit
      r0 = n_reads; d0 = n_deliv;
      load(28'h5A1B2C3);
      wait_rd_low(20, w);
      chk("t1_ef_to_rd", 32'(w), 32'd3);
      wait_idle(60);
      chk("t1_reads", 32'(n_reads - r0), 32'd1);
      chk("t1_deliv", 32'(n_deliv - d0), 32'd1);
      chk("t1_word", 32'(last_word), 32'h5A1B2C3);
`ifdef ACAM_READOUT_STATS_EN
      chk("t1_words_read", words_read_o, 32'd1);
`endif

      // burst of three
      r0 = n_reads; d0 = n_deliv;
      load(28'h1); load(28'h2); load(28'h3);
      wait_idle(100);
      chk("t2_reads", 32'(n_reads - r0), 32'd3);
      chk("t2_deliv", 32'(n_deliv - d0), 32'd3);
      chk("t2_last", 32'(last_word), 32'h3);

      // backpressure
      out_if.out_ready = 1'b0;
      r0 = n_reads;
      load(28'hABCDEF0); load(28'h0123456);
      repeat (30) step();
      chk("t3_one_read", 32'(n_reads - r0), 32'd1);
      chk("t3_valid_held", 32'(out_if.out_valid), 32'd1);
      chk("t3_rd_idle", 32'(tdc_rd_n_o), 32'd1);
`ifdef ACAM_READOUT_STATS_EN
      s0 = stall_cnt_o;
      repeat (5) step();
      chk("t3_stall_rate", stall_cnt_o - s0, 32'd5);
`else
      s0 = stall_cnt_o;
      chk("t3_stall_off", s0, 32'd0);
`endif
      out_if.out_ready = 1'b1;
      step();
      chk("t3_accepted", 32'(out_if.out_valid), 32'd0);
      chk("t3_not_yet", 32'(tdc_rd_n_o), 32'd1);
      step();
      chk("t3_b2b_read", 32'(tdc_rd_n_o), 32'd0);
      wait_idle(60);
      chk("t3_last", 32'(last_word), 32'h0123456);

      // enable dropped mid-read
      r0 = n_reads; d0 = n_deliv;
      load(28'h7777777); load(28'h8888888);
      wait_rd_low(20, w);
      enable = 1'b0;
      repeat (40) step();
      chk("t4_reads", 32'(n_reads - r0), 32'd1);
      chk("t4_deliv", 32'(n_deliv - d0), 32'd1);
      chk("t4_word", 32'(last_word), 32'h7777777);
      chk("t4_left", 32'(acam_q.size()), 32'd1);
      enable = 1'b1;
      wait_idle(60);

      // reset mid-read
      load(28'hEEEEEEE); load(28'hFFFFFF1);
      wait_rd_low(20, w);
      rst_n = 1'b0;
      void'(exp_q.pop_front());
      step();
      chk("t5_rd_n", 32'(tdc_rd_n_o), 32'd1);
      chk("t5_cs_n", 32'(tdc_cs_n_o), 32'd1);
      chk("t5_oe_n", 32'(tdc_oe_n_o), 32'd1);
      chk("t5_valid", 32'(out_if.out_valid), 32'd0);
      step();
      rst_n = 1'b1;
      wait_rd_low(20, w);
      chk("t5_restart", 32'(w), 32'd3);
      wait_idle(60);
      chk("t5_word", 32'(last_word), 32'hFFFFFF1);

`ifdef ACAM_READOUT_STATS_EN
      // statistics wrap
      force dut.words_cnt = 32'hFFFF_FFFF;
      m_words = 32'hFFFF_FFFF;
      step();
      release dut.words_cnt;
      load(28'h0000042);
      wait_idle(60);
      chk("t6_wrap", words_read_o, 32'd0);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         out_if.out_ready = ($urandom_range(0, 3) != 0);
         enable = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 6) == 0) load(28'($urandom));
         step();
      end
      enable = 1'b1;
      out_if.out_ready = 1'b1;
      wait_idle(800);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
